vdp_super_palette: RTL
======================

Name: vdp_super_palette

Overview:
- 16-entry, 12-bit (4:4:4 RGB) palette RAM feeding the super-res pixel stage.
- The pixel stage drives a 4-bit palette index each clk; this block returns R/G/B nibbles one clk later.
- The CPU port writes entries with the VDP two-byte sequence (R/B byte, then G byte), with an auto-incrementing pointer.
- Sits between the I/O port decoder (write side) and the super-res pixel fetch stage (read side).

Parameters:
- ENTRIES, 16, number of palette entries; the index width is fixed at 4.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high
- vdp_super  input  1  super-res mode enable; 0 blocks writes and clears the byte phase
- pal_ptr_wr  input  1  one-clk strobe: load the write pointer
- pal_ptr_data  input  4  new pointer value
- pal_wr  input  1  one-clk strobe: palette data byte present
- pal_data  input  8  data byte
- PALETTE_ADDR2  input  4  read index from the pixel stage
- PALETTE_DATA_R2_OUT  output  4  red of the entry addressed the previous clk
- PALETTE_DATA_G2_OUT  output  4  green of that entry
- PALETTE_DATA_B2_OUT  output  4  blue of that entry
- pal_ptr  output  4  current write pointer
- pal_phase  output  1  0 = expecting R/B byte, 1 = expecting G byte

Behaviour:
- Reset (async, immediate):
  - entry i = {R=i, G=i, B=i}, i.e. a grey ramp (0x000 … 0xFFF).
  - pal_ptr = 0, pal_phase = 0, staging byte = 0.
  - All three data outputs = 0.
- Read port:
  - Registered: on every clk edge, outputs <= entry[PALETTE_ADDR2]. Latency is exactly 1 clk.
  - No enable; the read port runs regardless of vdp_super.
- Read/write same entry, same edge: the read returns the OLD value. The new value is visible from the next edge.
- Write sequence, gated by vdp_super = 1:
  - Phase 0 + pal_wr: stage R = pal_data[7:4], B = pal_data[3:0]; pal_phase -> 1. The entry is not modified.
  - Phase 1 + pal_wr: entry[pal_ptr] <= {staged R, G = pal_data[3:0], staged B}. pal_data[7:4] is ignored. pal_phase -> 0; pal_ptr -> pal_ptr + 1, modulo 16 (15 wraps to 0).
  - The entry is committed atomically on the second byte only; a half-written entry is never visible.
- Pointer load:
  - pal_ptr_wr: pal_ptr <= pal_ptr_data, pal_phase <= 0, staging discarded.
  - pal_ptr_wr has priority when coincident with pal_wr; that pal_wr is dropped.
- vdp_super = 0:
  - pal_wr ignored; pal_phase forced to 0 each clk.
  - pal_ptr_wr still honoured.
  - Entries are retained.
- Back-to-back pal_wr on consecutive clks is legal; a full entry can be written in 2 clks.
- Gaps of any length between the two bytes are legal; the phase holds.

Test Plan:
- Reset, then PALETTE_ADDR2 = 5 -> RGB = 5/5/5 on the next clk; index 15 -> F/F/F; reset asserted mid-stream -> outputs 0 immediately.
- ptr_wr 3; wr 0xA7; wr 0x0C -> entry 3 = R A, G C, B 7; pal_ptr = 4, pal_phase = 0; read index 3 -> A/C/7 one clk later.
- ptr_wr 15; write 2 entries (0x12, 0x03, 0x45, 0x06) -> entry 15 = 1/3/2, entry 0 = 4/6/5; pal_ptr = 1 (wrap).
- Read index 3 while committing entry 3 (old 3/3/3, new F/0/F) on the same edge -> output 3/3/3 that clk, F/0/F on the following clk.
- wr 0xFF (phase 1), then ptr_wr 8 coincident with wr 0x11 -> pal_ptr = 8, phase 0, no entry changed.
- vdp_super = 0: wr 0x11, wr 0x22 -> no entry change, pal_phase stays 0; ptr_wr 2 -> pal_ptr = 2.

Source files
------------

// File: rtl/vdp_super_palette.sv
// vdp_super_palette
//   16-entry 4:4:4 RGB palette RAM for the super-res pixel stage.
//   Read side : PALETTE_ADDR2 is sampled every clk; the addressed entry appears
//               on PALETTE_DATA_{R,G,B}2_OUT one clk later (old data on a
//               same-edge write to the same entry).
//   Write side: CPU writes an entry as two bytes (R/B, then G) at pal_ptr,
//               which then auto-increments modulo 16. pal_ptr_wr reloads the
//               pointer and restarts the byte sequence.
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   vdp_super           super-res enable; 0 drops pal_wr and clears the phase
//   pal_ptr_wr          strobe: load pal_ptr from pal_ptr_data
//   pal_ptr_data        new pointer value
//   pal_wr              strobe: pal_data holds a palette byte
//   pal_data            palette byte
//   PALETTE_ADDR2       read index from the pixel stage
//   PALETTE_DATA_*2_OUT registered colour nibbles of the previously addressed entry
//   pal_ptr             current write pointer
//   pal_phase           0 = expecting R/B byte, 1 = expecting G byte
module vdp_super_palette #(
  parameter int ENTRIES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vdp_super,
  input  logic       pal_ptr_wr,
  input  logic [3:0] pal_ptr_data,
  input  logic       pal_wr,
  input  logic [7:0] pal_data,
  input  logic [3:0] PALETTE_ADDR2,
  output logic [3:0] PALETTE_DATA_R2_OUT,
  output logic [3:0] PALETTE_DATA_G2_OUT,
  output logic [3:0] PALETTE_DATA_B2_OUT,
  output logic [3:0] pal_ptr,
  output logic       pal_phase
);

  localparam int IW = 4;

  typedef enum logic {
    PH_RB = 1'b0,
    PH_G  = 1'b1
  } phase_t;

  // Entry layout {R, G, B}
  logic [11:0] mem [ENTRIES];

  phase_t      phase_q, phase_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  stage_q, stage_d;   // {R, B} captured from the first byte
  logic        commit;

  always_comb begin
    phase_d = phase_q;
    ptr_d   = ptr_q;
    stage_d = stage_q;
    commit  = 1'b0;
    if (pal_ptr_wr) begin
      ptr_d   = pal_ptr_data;
      phase_d = PH_RB;
      stage_d = '0;
    end else if (!vdp_super) begin
      phase_d = PH_RB;
    end else if (pal_wr) begin
      case (phase_q)
        PH_RB: begin
          stage_d = pal_data;
          phase_d = PH_G;
        end
        PH_G: begin
          commit  = 1'b1;
          phase_d = PH_RB;
          ptr_d   = ptr_q + 4'd1;
        end
        default: phase_d = PH_RB;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= PH_RB;
      ptr_q   <= '0;
      stage_q <= '0;
    end else begin
      phase_q <= phase_d;
      ptr_q   <= ptr_d;
      stage_q <= stage_d;
    end
  end

  // Read and write share one block so the read sees the pre-write contents
  // on a same-edge collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        mem[IW'(i)] <= {3{IW'(i)}};
      end
      PALETTE_DATA_R2_OUT <= '0;
      PALETTE_DATA_G2_OUT <= '0;
      PALETTE_DATA_B2_OUT <= '0;
    end else begin
      PALETTE_DATA_R2_OUT <= mem[PALETTE_ADDR2][11:8];
      PALETTE_DATA_G2_OUT <= mem[PALETTE_ADDR2][7:4];
      PALETTE_DATA_B2_OUT <= mem[PALETTE_ADDR2][3:0];
      if (commit) begin
        mem[ptr_q] <= {stage_q[7:4], pal_data[3:0], stage_q[3:0]};
      end
    end
  end

  assign pal_ptr   = ptr_q;
  assign pal_phase = (phase_q == PH_G);

endmodule
